// File: rtl/mem_arbiter_pkg.sv
// Shared constants and types for the dual-port RAM arbiter.
// Master ids, default bus widths and the read-return tag layout.
package mem_arbiter_pkg;

    localparam int unsigned AW_DEF = 16;
    localparam int unsigned DW_DEF = 8;

    localparam logic MID_M0 = 1'b0;
    localparam logic MID_M1 = 1'b1;

    // Identifies which master owns the read data returning this cycle.
    typedef struct packed {
        logic valid;
        logic id;
    } rd_tag_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// One master's read and write handshake onto the shared RAM.
// The master modport is the requester side; the slave modport is the arbiter side.
interface mem_arbiter_if #(
    parameter int unsigned AW = 16,
    parameter int unsigned DW = 8
);
    logic          ren;
    logic [AW-1:0] raddr;
    logic          rgnt;
    logic          rvalid;
    logic [DW-1:0] rdata;
    logic          wen;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic          wgnt;

    modport master (
        output ren, raddr, wen, waddr, wdata,
        input  rgnt, rvalid, rdata, wgnt
    );

    modport slave (
        input  ren, raddr, wen, waddr, wdata,
        output rgnt, rvalid, rdata, wgnt
    );
endinterface

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: grant is combinational, one-hot or zero,
// and the last-winner flop makes the other master win the next contention.
module rr_arb2
    import mem_arbiter_pkg::*;
(
    input  logic       clock,
    input  logic       reset_n,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic last_q;
    logic last_d;

    // No grant while reset is held, so the RAM sees no access during reset.
    always_comb begin
        gnt    = 2'b00;
        last_d = last_q;
        if (reset_n) begin
            if (req == 2'b11) begin
                gnt = (last_q == MID_M0) ? 2'b10 : 2'b01;
            end else begin
                gnt = req;
            end
        end
        if (gnt[1]) begin
            last_d = MID_M1;
        end else if (gnt[0]) begin
            last_d = MID_M0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            last_q <= MID_M1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares a dual-port byte RAM between two masters with independent read/write arbitration.
// Define MEM_ARB_FWD_EN to return same-cycle write data to a colliding read.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned AW = AW_DEF,
    parameter int unsigned DW = DW_DEF
) (
    input  logic           clock,
    input  logic           reset_n,
    mem_arbiter_if.slave   m0,
    mem_arbiter_if.slave   m1,
    output logic           ram_ren,
    output logic [AW-1:0]  ram_raddr,
    input  logic [DW-1:0]  ram_rdata,
    output logic           ram_wen,
    output logic [AW-1:0]  ram_waddr,
    output logic [DW-1:0]  ram_wdata
);

    logic [1:0]    rgnt_c;
    logic [1:0]    wgnt_c;
    logic [DW-1:0] rdata_c;
    rd_tag_t       rd_tag_q;
    rd_tag_t       rd_tag_d;

    rr_arb2 u_rd_arb (
        .clock   (clock),
        .reset_n (reset_n),
        .req     ({m1.ren, m0.ren}),
        .gnt     (rgnt_c)
    );

    rr_arb2 u_wr_arb (
        .clock   (clock),
        .reset_n (reset_n),
        .req     ({m1.wen, m0.wen}),
        .gnt     (wgnt_c)
    );

    // Muxes default to M0 so the RAM pins never float to X on an idle port.
    always_comb begin
        ram_ren   = |rgnt_c;
        ram_raddr = rgnt_c[1] ? m1.raddr : m0.raddr;
        ram_wen   = |wgnt_c;
        ram_waddr = wgnt_c[1] ? m1.waddr : m0.waddr;
        ram_wdata = wgnt_c[1] ? m1.wdata : m0.wdata;
        rd_tag_d  = '{valid: ram_ren, id: rgnt_c[1]};
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rd_tag_q <= '{valid: 1'b0, id: MID_M0};
        end else begin
            rd_tag_q <= rd_tag_d;
        end
    end

`ifdef MEM_ARB_FWD_EN
    logic          fwd_hit_q;
    logic          fwd_hit_d;
    logic [DW-1:0] fwd_data_q;
    logic [DW-1:0] fwd_data_d;

    always_comb begin
        fwd_hit_d  = ram_ren && ram_wen && (ram_raddr == ram_waddr);
        fwd_data_d = ram_wdata;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            fwd_hit_q  <= 1'b0;
            fwd_data_q <= '0;
        end else begin
            fwd_hit_q  <= fwd_hit_d;
            fwd_data_q <= fwd_data_d;
        end
    end

    assign rdata_c = fwd_hit_q ? fwd_data_q : ram_rdata;
`else
    assign rdata_c = ram_rdata;
`endif

    assign m0.rgnt = rgnt_c[0];
    assign m1.rgnt = rgnt_c[1];
    assign m0.wgnt = wgnt_c[0];
    assign m1.wgnt = wgnt_c[1];

    // Gating with reset_n drops a pending return the moment reset asserts.
    assign m0.rvalid = reset_n && rd_tag_q.valid && (rd_tag_q.id == MID_M0);
    assign m1.rvalid = reset_n && rd_tag_q.valid && (rd_tag_q.id == MID_M1);
    assign m0.rdata  = rdata_c;
    assign m1.rdata  = rdata_c;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: table of per-cycle vectors plus reset sequences.
module tb_mem_arbiter;

    logic        clock;
    logic        reset_n;
    logic        ram_ren;
    logic [15:0] ram_raddr;
    logic [7:0]  ram_rdata;
    logic        ram_wen;
    logic [15:0] ram_waddr;
    logic [7:0]  ram_wdata;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef MEM_ARB_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    mem_arbiter_if #(.AW(16), .DW(8)) m0_if ();
    mem_arbiter_if #(.AW(16), .DW(8)) m1_if ();

    mem_arbiter #(.AW(16), .DW(8)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .m0        (m0_if),
        .m1        (m1_if),
        .ram_ren   (ram_ren),
        .ram_raddr (ram_raddr),
        .ram_rdata (ram_rdata),
        .ram_wen   (ram_wen),
        .ram_waddr (ram_waddr),
        .ram_wdata (ram_wdata)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Behavioural dual-port RAM, read-before-write on a same-address collision.
    logic [7:0] mem [0:65535];
    always @(posedge clock) begin
        if (ram_ren) ram_rdata <= mem[ram_raddr];
        if (ram_wen) mem[ram_waddr] <= ram_wdata;
    end

    typedef struct {
        logic        r0;
        logic [15:0] ra0;
        logic        w0;
        logic [15:0] wa0;
        logic [7:0]  wd0;
        logic        r1;
        logic [15:0] ra1;
        logic        w1;
        logic [15:0] wa1;
        logic [7:0]  wd1;
        logic [3:0]  gnt;     // {m1_wgnt, m0_wgnt, m1_rgnt, m0_rgnt}
        logic [1:0]  rvalid;  // {m1_rvalid, m0_rvalid}
        logic [7:0]  rdata;
    } vec_t;

    localparam int NV = 21;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic r0, input logic [15:0] ra0,
                                input logic w0, input logic [15:0] wa0, input logic [7:0] wd0,
                                input logic r1, input logic [15:0] ra1,
                                input logic w1, input logic [15:0] wa1, input logic [7:0] wd1,
                                input logic [3:0] gnt, input logic [1:0] rvalid,
                                input logic [7:0] rdata);
        vec_t v;
        v.r0 = r0; v.ra0 = ra0; v.w0 = w0; v.wa0 = wa0; v.wd0 = wd0;
        v.r1 = r1; v.ra1 = ra1; v.w1 = w1; v.wa1 = wa1; v.wd1 = wd1;
        v.gnt = gnt; v.rvalid = rvalid; v.rdata = rdata;
        return v;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        m0_if.ren = 1'b0; m0_if.raddr = 16'h0; m0_if.wen = 1'b0; m0_if.waddr = 16'h0; m0_if.wdata = 8'h0;
        m1_if.ren = 1'b0; m1_if.raddr = 16'h0; m1_if.wen = 1'b0; m1_if.waddr = 16'h0; m1_if.wdata = 8'h0;
    endtask

    function automatic logic [3:0] gnts();
        return {m1_if.wgnt, m0_if.wgnt, m1_if.rgnt, m0_if.rgnt};
    endfunction

    initial begin
        for (int a = 0; a < 65536; a++) mem[a] = 8'h00;

        vecs[0]  = mk(0,16'h0000, 1,16'h0100,8'h5A, 0,16'h0000, 0,16'h0000,8'h00, 4'b0100, 2'b00, 8'h00);
        vecs[1]  = mk(1,16'h0100, 0,16'h0000,8'h00, 0,16'h0000, 0,16'h0000,8'h00, 4'b0001, 2'b00, 8'h00);
        vecs[2]  = mk(0,16'h0000, 0,16'h0000,8'h00, 0,16'h0000, 0,16'h0000,8'h00, 4'b0000, 2'b01, 8'h5A);
        vecs[3]  = mk(0,16'h0000, 1,16'h0040,8'hA0, 0,16'h0000, 1,16'h0041,8'hA1, 4'b1000, 2'b00, 8'h00);
        vecs[4]  = mk(0,16'h0000, 1,16'h0040,8'hA0, 0,16'h0000, 0,16'h0000,8'h00, 4'b0100, 2'b00, 8'h00);
        vecs[5]  = mk(1,16'h0040, 0,16'h0000,8'h00, 1,16'h0041, 0,16'h0000,8'h00, 4'b0010, 2'b00, 8'h00);
        vecs[6]  = mk(1,16'h0040, 0,16'h0000,8'h00, 1,16'h0041, 0,16'h0000,8'h00, 4'b0001, 2'b10, 8'hA1);
        vecs[7]  = mk(1,16'h0040, 0,16'h0000,8'h00, 1,16'h0041, 0,16'h0000,8'h00, 4'b0010, 2'b01, 8'hA0);
        vecs[8]  = mk(1,16'h0040, 0,16'h0000,8'h00, 1,16'h0041, 0,16'h0000,8'h00, 4'b0001, 2'b10, 8'hA1);
        vecs[9]  = mk(0,16'h0000, 0,16'h0000,8'h00, 0,16'h0000, 0,16'h0000,8'h00, 4'b0000, 2'b01, 8'hA0);
        vecs[10] = mk(1,16'h0010, 0,16'h0000,8'h00, 0,16'h0000, 1,16'h0020,8'hC3, 4'b1001, 2'b00, 8'h00);
        vecs[11] = mk(0,16'h0000, 0,16'h0000,8'h00, 1,16'h0020, 0,16'h0000,8'h00, 4'b0010, 2'b01, 8'h00);
        vecs[12] = mk(0,16'h0000, 0,16'h0000,8'h00, 0,16'h0000, 0,16'h0000,8'h00, 4'b0000, 2'b10, 8'hC3);
        vecs[13] = mk(0,16'h0000, 1,16'h0030,8'h11, 0,16'h0000, 0,16'h0000,8'h00, 4'b0100, 2'b00, 8'h00);
        vecs[14] = mk(0,16'h0000, 1,16'h0030,8'h22, 1,16'h0030, 0,16'h0000,8'h00, 4'b0110, 2'b00, 8'h00);
        vecs[15] = mk(0,16'h0000, 0,16'h0000,8'h00, 0,16'h0000, 0,16'h0000,8'h00, 4'b0000, 2'b10,
                      FWD ? 8'h22 : 8'h11);
        vecs[16] = mk(1,16'h0030, 0,16'h0000,8'h00, 0,16'h0000, 0,16'h0000,8'h00, 4'b0001, 2'b00, 8'h00);
        vecs[17] = mk(0,16'h0000, 0,16'h0000,8'h00, 0,16'h0000, 0,16'h0000,8'h00, 4'b0000, 2'b01, 8'h22);
        vecs[18] = mk(0,16'h0000, 1,16'h0050,8'h01, 0,16'h0000, 1,16'h0051,8'h02, 4'b1000, 2'b00, 8'h00);
        vecs[19] = mk(0,16'h0000, 1,16'h0050,8'h01, 0,16'h0000, 1,16'h0051,8'h02, 4'b0100, 2'b00, 8'h00);
        vecs[20] = mk(0,16'h0000, 1,16'h0050,8'h01, 0,16'h0000, 1,16'h0051,8'h02, 4'b1000, 2'b00, 8'h00);

        // Reset held with live requests: nothing may reach the RAM.
        reset_n = 1'b0;
        drive_idle();
        m0_if.ren = 1'b1;
        m1_if.wen = 1'b1;
        m1_if.waddr = 16'h0100;
        m1_if.wdata = 8'hEE;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            #1;
            check($sformatf("reset%0d_gnts", i), 16'(gnts()), 16'h0);
            check($sformatf("reset%0d_ram_en", i), 16'({ram_wen, ram_ren}), 16'h0);
            check($sformatf("reset%0d_rvalid", i), 16'({m1_if.rvalid, m0_if.rvalid}), 16'h0);
        end
        @(negedge clock);
        drive_idle();
        reset_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(negedge clock);
            m0_if.ren = vecs[i].r0; m0_if.raddr = vecs[i].ra0;
            m0_if.wen = vecs[i].w0; m0_if.waddr = vecs[i].wa0; m0_if.wdata = vecs[i].wd0;
            m1_if.ren = vecs[i].r1; m1_if.raddr = vecs[i].ra1;
            m1_if.wen = vecs[i].w1; m1_if.waddr = vecs[i].wa1; m1_if.wdata = vecs[i].wd1;
            #1;
            check($sformatf("v%0d_gnts", i), 16'(gnts()), 16'(vecs[i].gnt));
            check($sformatf("v%0d_ram_en", i), 16'({ram_wen, ram_ren}),
                  16'({|vecs[i].gnt[3:2], |vecs[i].gnt[1:0]}));
            check($sformatf("v%0d_rvalid", i), 16'({m1_if.rvalid, m0_if.rvalid}), 16'(vecs[i].rvalid));
            if (vecs[i].gnt[0]) check($sformatf("v%0d_raddr", i), ram_raddr, vecs[i].ra0);
            if (vecs[i].gnt[1]) check($sformatf("v%0d_raddr", i), ram_raddr, vecs[i].ra1);
            if (vecs[i].gnt[2]) check($sformatf("v%0d_wdata", i), 16'(ram_wdata), 16'(vecs[i].wd0));
            if (vecs[i].gnt[3]) check($sformatf("v%0d_wdata", i), 16'(ram_wdata), 16'(vecs[i].wd1));
            if (vecs[i].rvalid[0]) check($sformatf("v%0d_m0_rdata", i), 16'(m0_if.rdata), 16'(vecs[i].rdata));
            if (vecs[i].rvalid[1]) check($sformatf("v%0d_m1_rdata", i), 16'(m1_if.rdata), 16'(vecs[i].rdata));
        end

        // Reset asserted right after an M1 read grant: its data must never be flagged.
        @(negedge clock);
        drive_idle();
        m1_if.ren = 1'b1;
        m1_if.raddr = 16'h0040;
        #1;
        check("midrd_m1_rgnt", 16'(m1_if.rgnt), 16'h1);
        @(posedge clock);
        #1;
        reset_n = 1'b0;
        m1_if.ren = 1'b0;
        #1;
        check("midrd_rvalid_now", 16'({m1_if.rvalid, m0_if.rvalid}), 16'h0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            #1;
            check($sformatf("midrd_rvalid_rst%0d", i), 16'({m1_if.rvalid, m0_if.rvalid}), 16'h0);
        end
        @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            #1;
            check($sformatf("midrd_rvalid_post%0d", i), 16'({m1_if.rvalid, m0_if.rvalid}), 16'h0);
        end

        // After reset M0 wins the first contention on both ports.
        @(negedge clock);
        m0_if.ren = 1'b1; m1_if.ren = 1'b1;
        m0_if.wen = 1'b1; m1_if.wen = 1'b1;
        m0_if.waddr = 16'h0060; m1_if.waddr = 16'h0061;
        #1;
        check("post_rst_first_gnts", 16'(gnts()), 16'h5);
        @(negedge clock);
        #1;
        check("post_rst_second_gnts", 16'(gnts()), 16'hA);
        drive_idle();

        @(negedge clock);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
